// File: rtl/bram_rd_pkg.sv
// Shared types and sizing for the BRAM burst reader: controller states,
// output FIFO entry layout and FIFO depth derived from the RAM read latency.
package bram_rd_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Room for every read still in the RAM pipeline plus headroom so a stream
    // with the consumer always ready never runs out of issue credit.
    function automatic int fifoDepth(input int readLatency);
        return readLatency + 2;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO with a registered head word; the head register is
// refreshed on every edge so a push into an empty FIFO is visible next cycle.
module bram_rd_fifo #(
    parameter int  WIDTH = 33,
    parameter int  DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             popEn;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign popEn   = pop_i && !empty_o;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

    // The new head is the word being written when it lands in the slot the
    // read pointer is about to point at; otherwise it is already in storage.
    always_comb begin
        rdPtr_d = popEn ? nextPtr(rdPtr_q) : rdPtr_q;
        wrPtr_d = push_i ? nextPtr(wrPtr_q) : wrPtr_q;
        count_d = count_q;
        if (push_i && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && popEn) begin
            count_d = count_q - 1'b1;
        end
        head_d = (push_i && (wrPtr_q == rdPtr_d)) ? wdata_i : mem_q[rdPtr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    noOverflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read master for one BRAM read port: issues addresses only while the
// output FIFO has credit, so an unstallable RAM never loses a word.
module bram_burst_reader
    import bram_rd_pkg::*;
#(
    parameter int  RAM_WIDTH    = DATA_W,
    parameter int  RAM_DEPTH    = 1024,
    parameter int  READ_LATENCY = 1,
    localparam int AW           = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [AW:0]          cmd_len,
    output logic [AW-1:0]        ram_addr,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int FIFO_DEPTH = fifoDepth(READ_LATENCY);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d, addrInc;
    logic [AW:0]             remain_q, remain_d;
    logic [READ_LATENCY-1:0] validPipe_q, lastPipe_q;
    logic [CW-1:0]           fifoCount;
    logic                    fifoFull, fifoEmpty;
    int                      inflightCount;
    logic                    credit, issue, pop;
    fifo_entry_t             pushEntry, headEntry;

    assign inflightCount = $countones(validPipe_q);
    assign credit        = !fifoFull && ((int'(fifoCount) + inflightCount) < FIFO_DEPTH);
    assign issue         = (state_q == RUN) && credit;
    assign pop           = m_valid && m_ready;
    assign addrInc       = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    state_d  = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addrInc;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (AW + 1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // Handing off the tagged last beat means nothing is left in flight.
            DRAIN: begin
                if (pop && headEntry.last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // Tracks each issued read through the RAM so its data is captured exactly
    // when it appears on ram_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe_q <= '0;
            lastPipe_q  <= '0;
        end else begin
            validPipe_q[0] <= issue;
            lastPipe_q[0]  <= (remain_q == (AW + 1)'(1));
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                lastPipe_q[i]  <= lastPipe_q[i-1];
            end
        end
    end

    always_comb begin
        pushEntry      = '0;
        pushEntry.last = lastPipe_q[READ_LATENCY-1];
        pushEntry.data = ram_dout;
    end

    bram_rd_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (validPipe_q[READ_LATENCY-1]),
        .wdata_i (pushEntry),
        .pop_i   (pop),
        .head_o  (headEntry),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign ram_addr  = addr_q;
    assign m_valid   = !fifoEmpty;
    assign m_data    = headEntry.data;
    assign m_last    = headEntry.last;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Read-side master for the team's true-dual-port BRAM. Drives one RAM read port (address out, data in).
- Accepts burst commands (start address, length) and streams the words out on a valid/ready interface with `m_last`.
- The RAM has no read enable and cannot be stalled, so backpressure is absorbed by credit-limited issue into a small output FIFO.
- Sits directly downstream of the RAM; feeds compute/DMA consumers.

Parameters:
- RAM_WIDTH, 32, data word width; must match the RAM.
- RAM_DEPTH, 1024, number of RAM words; address width AW = $clog2(RAM_DEPTH).
- READ_LATENCY, 1, cycles from the address-sampling edge to valid RAM data. Legal values: 1 (LOW_LATENCY RAM), 2 (HIGH_PERFORMANCE RAM).

Ports:
- clk  in  1  single clock, shared with the RAM port it drives.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  AW  start word address.
- cmd_len  in  AW+1  burst length in words, 0..RAM_DEPTH.
- ram_addr  out  AW  to RAM addr port; driven from the internal address counter.
- ram_dout  in  RAM_WIDTH  from RAM dout port.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  RAM_WIDTH  stream word.
- m_last  out  1  final word of the burst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (async assert, clears all state): state = IDLE, cmd_ready = 1, m_valid = 0, m_last = 0, m_data = 0, busy = 0, done = 0, ram_addr = 0. FIFO and in-flight pipeline are cleared. RAM output arriving after reset is ignored.
- States:
  - IDLE: on cmd_valid, latch addr and len. len = 0 goes to DONE; otherwise RUN.
  - RUN: issue reads until the remaining-issue count reaches 0, then go to DRAIN.
  - DRAIN: wait until the in-flight count is 0, the FIFO is empty and the last beat has handshaken, then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Issue:
  - An issue occurs in RUN when fifo_count + inflight_count < FIFO_DEPTH, where FIFO_DEPTH = READ_LATENCY + 2.
  - No credit is taken for a same-cycle pop.
  - At an issue edge the RAM samples ram_addr; the address counter increments modulo RAM_DEPTH (RAM_DEPTH-1 wraps to 0).
- In-flight tracking:
  - A READ_LATENCY-deep valid shift pipeline carries {valid, last}. last = 1 when the remaining-issue count is 1 at issue.
  - When the pipeline output is valid, ram_dout plus the last tag are pushed into the FIFO on that edge.
  - Overflow is impossible by construction; a push into a full FIFO is an assertion failure.
- Output:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
  - Pop on m_valid && m_ready.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - The pop-side FIFO outputs are registered.
- Latency: first m_valid is asserted READ_LATENCY + 1 cycles after the command-accept edge.
- Throughput: one beat per cycle sustained with m_ready held high, for either latency.
- Ordering: words are emitted in address order, exactly cmd_len beats, and m_last appears only on the final beat.
- cmd_valid outside IDLE is ignored (cmd_ready = 0). No command queueing.
- Burst of len = RAM_DEPTH: every word is read exactly once, including wrap when cmd_addr != 0.
- done and cmd_ready: done rises the cycle after the last-beat handshake; cmd_ready rises the cycle after done.
- Reset mid-burst: outputs drop to reset values asynchronously, with no partial-burst done. The next command behaves as from cold reset.

Decomposition:
- Package bram_rd_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the FIFO_DEPTH constant function of READ_LATENCY;
  - the FIFO entry struct {last, data}.
- One sub-module, bram_rd_fifo: synchronous FIFO with async reset, parameterized width and depth, providing count, full, empty and a registered head.

Test Plan:
1. RAM preloaded ram[i] = i; cmd addr 10, len 4, m_ready = 1, READ_LATENCY = 1 -> data 10, 11, 12, 13 on consecutive cycles. First m_valid 2 cycles after accept; m_last only with 13; done 1 cycle after the last handshake.
2. cmd addr 1022, len 4 -> data 1022, 1023, 0, 1; ram_addr observed wrapping to 0.
3. cmd addr 0, len 16, m_ready low for 10 cycles then random toggling -> at most FIFO_DEPTH reads outstanding, no loss or duplication, data 0..15 in order, m_data stable while stalled.
4. cmd len 0 -> no m_valid, done pulse within 2 cycles, cmd_ready returns high; cmd_valid in RUN is ignored.
5. rst asserted asynchronously after 2 beats of a len-8 burst -> m_valid = 0 immediately, no done. A new cmd addr 100, len 3 yields 100, 101, 102 correctly.
6. READ_LATENCY = 2, cmd addr 512, len 1024, m_ready = 1 -> 1024 beats on consecutive cycles (512..1023, 0..511). First m_valid 3 cycles after accept; m_last on word 511.
